// File: rtl/wb_arbiter_pkg.sv
// Purpose : shared widths, register-file constants and write-source encodings
//           for the writeback arbiter slice.
// Latency : n/a (declarations only). Backpressure: n/a.
package wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   localparam int DEPTH_DEF        = 2;
   localparam int STARVE_LIMIT_DEF = 8;
   localparam int CNT_W_DEF        = 4;

   // Which source owns the register-file write port in a given cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_EX   = 2'd1,
      SRC_DIV  = 2'd2,
      SRC_JTAG = 2'd3
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Purpose : small buffer for long-latency results, one valid bit per entry so
//           a newer ex write to the same register can cancel a stored result.
// Latency : an entry is visible at the head the cycle after it is pushed.
// Backpressure: full_o blocks pushes; pop_i is honoured only when not empty.
// Ports   : push_i/push_addr_i/push_data_i - write an entry (ignored when full)
//           pop_i                           - remove the head entry
//           kill_i/kill_addr_i              - invalidate entries with that address
//           head_vld_o/head_addr_o/head_data_o, full_o, empty_o - status
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [REG_ADDR_W-1:0] push_addr_i,
   input  logic [REG_DATA_W-1:0] push_data_i,
   input  logic                  pop_i,
   input  logic                  kill_i,
   input  logic [REG_ADDR_W-1:0] kill_addr_i,
   output logic                  head_vld_o,
   output logic [REG_ADDR_W-1:0] head_addr_o,
   output logic [REG_DATA_W-1:0] head_data_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0]        vld_q, vld_d;
   logic [REG_ADDR_W-1:0]   addr_q [DEPTH];
   logic [REG_ADDR_W-1:0]   addr_d [DEPTH];
   logic [REG_DATA_W-1:0]   data_q [DEPTH];
   logic [REG_DATA_W-1:0]   data_d [DEPTH];
   logic [PTR_W-1:0]        wr_idx, rd_idx;

   assign wr_idx  = wr_ptr_q[PTR_W-1:0];
   assign rd_idx  = rd_ptr_q[PTR_W-1:0];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign head_vld_o  = vld_q[rd_idx] && !empty_o;
   assign head_addr_o = addr_q[rd_idx];
   assign head_data_o = data_q[rd_idx];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      vld_d    = vld_q;
      addr_d   = addr_q;
      data_d   = data_q;

      // Kill is applied to every slot; stale slots outside the occupied
      // range are harmless because a push always sets its valid bit again.
      for (int i = 0; i < DEPTH; i++) begin
         if (kill_i && (addr_q[i] == kill_addr_i)) begin
            vld_d[i] = 1'b0;
         end
      end

      if (push_i && !full_o) begin
         vld_d[wr_idx]  = 1'b1;
         addr_d[wr_idx] = push_addr_i;
         data_d[wr_idx] = push_data_i;
         wr_ptr_d       = wr_ptr_q + PTR_ONE;
      end

      if (pop_i && !empty_o) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         vld_q    <= vld_d;
      end
   end

   // Payload needs no reset: it is only observed through a valid entry.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Purpose : merges ex results, buffered mul/div results and JTAG debug writes
//           onto the single register-file write port, keeping WAW order.
// Latency : 0 cycles from granted source to we_o/waddr_o/wdata_o (pure mux).
// Backpressure: div_ready_o = !full (pre-pop); JTAG waits for jtag_ack_o,
//           raising hold_o after STARVE_LIMIT ungranted cycles.
// Ports   : ex_*   - single-cycle results, always win
//           div_*  - valid/ready long-latency results
//           jtag_* - level request, one-cycle ack
//           we_o/waddr_o/wdata_o - register-file write port; hold_o - pipeline hold
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH        = DEPTH_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_we_i,
   input  logic [4:0]  ex_waddr_i,
   input  logic [31:0] ex_wdata_i,
   input  logic        div_valid_i,
   input  logic [4:0]  div_waddr_i,
   input  logic [31:0] div_wdata_i,
   output logic        div_ready_o,
   input  logic        jtag_req_i,
   input  logic [4:0]  jtag_addr_i,
   input  logic [31:0] jtag_wdata_i,
   output logic        jtag_ack_o,
   output logic        hold_o,
   output logic        we_o,
   output logic [4:0]  waddr_o,
   output logic [31:0] wdata_o
);

   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);

   logic                  ex_w;
   logic                  jtag_elig;
   logic                  fifo_push, fifo_pop;
   logic                  head_vld, fifo_full, fifo_empty;
   logic [REG_ADDR_W-1:0] head_addr;
   logic [REG_DATA_W-1:0] head_data;
   logic                  jtag_grant;
   wb_src_e               sel;

   logic                  jtag_ack_q, jtag_ack_d;
   logic                  hold_q, hold_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   assign ex_w = ex_we_i && (ex_waddr_i != ZERO_REG);

   // A request still high in its ack cycle is the old one; do not grant again.
   assign jtag_elig = jtag_req_i && !jtag_ack_q;

   assign div_ready_o = !fifo_full;

   // A result whose register is x0, or which a same-cycle ex write supersedes,
   // is handshaken but never stored.
   assign fifo_push = div_valid_i && !fifo_full && !rst &&
                      (div_waddr_i != ZERO_REG) &&
                      !(ex_w && (div_waddr_i == ex_waddr_i));

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (fifo_push),
      .push_addr_i (div_waddr_i),
      .push_data_i (div_wdata_i),
      .pop_i       (fifo_pop),
      .kill_i      (ex_w),
      .kill_addr_i (ex_waddr_i),
      .head_vld_o  (head_vld),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // One owner per cycle. Under hold, JTAG jumps ahead of the FIFO head.
   always_comb begin
      sel = SRC_NONE;
      if (!rst) begin
         if (ex_w) begin
            sel = SRC_EX;
         end else if (hold_q) begin
            if (jtag_elig)        sel = SRC_JTAG;
            else if (!fifo_empty) sel = SRC_DIV;
         end else begin
            if (!fifo_empty)      sel = SRC_DIV;
            else if (jtag_elig)   sel = SRC_JTAG;
         end
      end
   end

   // An invalid (killed) head still uses its grant: it pops without writing.
   assign fifo_pop   = (sel == SRC_DIV);
   assign jtag_grant = (sel == SRC_JTAG);

   always_comb begin
      we_o    = 1'b0;
      waddr_o = '0;
      wdata_o = '0;
      case (sel)
         SRC_EX: begin
            we_o    = 1'b1;
            waddr_o = ex_waddr_i;
            wdata_o = ex_wdata_i;
         end
         SRC_DIV: begin
            if (head_vld) begin
               we_o    = 1'b1;
               waddr_o = head_addr;
               wdata_o = head_data;
            end
         end
         SRC_JTAG: begin
            if (jtag_addr_i != ZERO_REG) begin
               we_o    = 1'b1;
               waddr_o = jtag_addr_i;
               wdata_o = jtag_wdata_i;
            end
         end
         default: begin
            we_o = 1'b0;
         end
      endcase
   end

   always_comb begin
      jtag_ack_d = jtag_grant;

      cnt_d = '0;
      if (jtag_req_i && !jtag_grant) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end

      // Hold also drops if the requester withdraws, so the pipeline can
      // never be left stalled with nobody waiting.
      hold_d = hold_q;
      if (jtag_grant || !jtag_req_i) begin
         hold_d = 1'b0;
      end else if (cnt_q == CNT_TRIP) begin
         hold_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         jtag_ack_q <= 1'b0;
         hold_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         jtag_ack_q <= jtag_ack_d;
         hold_q     <= hold_d;
         cnt_q      <= cnt_d;
      end
   end

   assign jtag_ack_o = jtag_ack_q;
   assign hold_o     = hold_q;

endmodule
